// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Produces Load enables for PC, IF/ID, ID/EX, EX/MEM, MEM/WB and the flush
// strobes for IF/ID and ID/EX. Enables and flushes are Mealy outputs of the
// registered state and the current hazard inputs, so they act on the same edge.

module pipeline_ctrl #(
    parameter int unsigned RA_W        = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_mem_read,
    input  logic [RA_W-1:0] ex_rt,
    input  logic            ex_branch_taken,
    input  logic            mem_req,
    input  logic            mem_ready,
    input  logic            halt_req,
    output logic            pc_ld,
    output logic            ld_if_id,
    output logic            ld_id_ex,
    output logic            ld_ex_mem,
    output logic            ld_mem_wb,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            halt_ack,
    output logic            mem_timeout_err,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2,
        StErr    = 2'd3
    } state_e;

    // Last tolerated value of the wait counter before a stall becomes a timeout.
    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MEM_TIMEOUT - 1);

    // Number of advancing drain cycles minus one; the third advance empties EX/MEM/WB.
    localparam logic [1:0] DrainLast = 2'd2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;

    logic mstall;
    logic luh;
    logic timeout;
    logic rs_match;
    logic rt_match;

    // Hazard decode from the current pipeline contents.
    always_comb begin
        mstall   = mem_req & ~mem_ready;
        rs_match = (ex_rt == id_rs);
        rt_match = id_uses_rt & (ex_rt == id_rt);
        // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
        luh      = ex_mem_read & (ex_rt != '0) & (rs_match | rt_match);
        timeout  = mstall & (wait_cnt_q == WaitLast);
    end

    // State and counter registers, synchronously reset to an empty RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        drain_cnt_d = drain_cnt_q;

        unique case (state_q)
            StRun: begin
                if (mstall) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (timeout) begin
                        state_d = StErr;
                    end
                end else if (!ex_branch_taken && !luh && halt_req) begin
                    // Halt is only accepted on a clean cycle so no bubble or redirect is lost.
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end

            StDrain: begin
                if (mstall) begin
                    // Frozen: drain progress is held, only the wait counter moves.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (timeout) begin
                        state_d = StErr;
                    end else if (!halt_req) begin
                        state_d = StRun;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (!halt_req) begin
                        state_d = StRun;
                    end else if (drain_cnt_q == DrainLast) begin
                        state_d = StHalted;
                    end
                end
            end

            StHalted: begin
                if (!halt_req) begin
                    state_d = StRun;
                end
            end

            StErr: begin
                // Sticky until reset.
                state_d = StErr;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Mealy outputs: enables and flushes from the current state and hazards.
    always_comb begin
        pc_ld           = 1'b0;
        ld_if_id        = 1'b0;
        ld_id_ex        = 1'b0;
        ld_ex_mem       = 1'b0;
        ld_mem_wb       = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        halt_ack        = 1'b0;
        mem_timeout_err = 1'b0;

        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (mstall) begin
                        // Full freeze: every register holds while memory is busy.
                    end else if (ex_branch_taken) begin
                        pc_ld       = 1'b1;
                        ld_if_id    = 1'b1;
                        ld_id_ex    = 1'b1;
                        ld_ex_mem   = 1'b1;
                        ld_mem_wb   = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (luh) begin
                        // Hold PC and IF/ID, inject one bubble into ID/EX.
                        ld_id_ex    = 1'b1;
                        ld_ex_mem   = 1'b1;
                        ld_mem_wb   = 1'b1;
                        flush_id_ex = 1'b1;
                    end else begin
                        pc_ld     = 1'b1;
                        ld_if_id  = 1'b1;
                        ld_id_ex  = 1'b1;
                        ld_ex_mem = 1'b1;
                        ld_mem_wb = 1'b1;
                    end
                end

                StDrain: begin
                    if (!mstall) begin
                        // Back end keeps advancing while bubbles enter ID/EX.
                        ld_id_ex    = 1'b1;
                        ld_ex_mem   = 1'b1;
                        ld_mem_wb   = 1'b1;
                        flush_id_ex = 1'b1;
                        // A taken branch still redirects PC so the target is fetched on resume.
                        pc_ld       = ex_branch_taken;
                        flush_if_id = ex_branch_taken;
                    end
                end

                StHalted: begin
                    halt_ack = 1'b1;
                end

                StErr: begin
                    mem_timeout_err = 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

    // Debug view of the state; forced to RUN while reset is asserted.
    always_comb begin
        state = rst ? 2'd0 : state_q;
    end

endmodule
